axi_wr_arbiter: RTL
===================

# axi_wr_arbiter

Two-master arbiter for the AXI3 write path (AW, W, B channels) in front of a single AXI slave port in the AXI VIP environment. It grants one master at a time for a complete write transaction, round-robin between requesters. It forwards that master's address and data beats to the slave and routes the write response back to it. Write data from different transactions is never interleaved.

## Interface
- NUM_M, 2, number of masters (fixed at 2; index 0/1)
- ID_W, 4, AWID/WID/BID width
- ADDR_W, 32, AWADDR width
- DATA_W, 32, WDATA width (WSTRB is DATA_W/8)
- clk  input  1  clock, all logic on posedge
- rst  input  1  asynchronous, active-low reset
- m_AWID / m_AWADDR / m_AWLEN / m_AWSIZE / m_AWBURST  input  [NUM_M] x ID_W/ADDR_W/4/3/2  per-master write address
- m_AWVALID  input  [NUM_M]  per-master address valid; m_AWREADY  output  [NUM_M]
- m_WID / m_WDATA / m_WSTRB / m_WLAST / m_WVALID  input  [NUM_M] x ID_W/DATA_W/DATA_W/8/1/1  per-master write data
- m_WREADY  output  [NUM_M]  per-master write data ready
- m_BID / m_BRESP / m_BVALID  output  [NUM_M] x ID_W/2/1; m_BREADY  input  [NUM_M]
- s_AWID, s_AWADDR, s_AWLEN, s_AWSIZE, s_AWBURST, s_AWVALID  output  ID_W/ADDR_W/4/3/2/1  slave-side address; s_AWREADY  input  1
- s_WID, s_WDATA, s_WSTRB, s_WLAST, s_WVALID  output  ID_W/DATA_W/DATA_W/8/1/1; s_WREADY  input  1
- s_BID, s_BRESP, s_BVALID  input  ID_W/2/1; s_BREADY  output  1
- grant  output  [NUM_M]  one-hot current owner, all-zero in IDLE
- busy  output  1  high when state is not IDLE

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if any m_AWVALID is high, register a grant to the winner and go to ADDR. Winner is the requester that is not the last-served master. If only one master requests, it wins. prio_last resets to 1, so master 0 wins the first contention.
- ADDR: combinationally forward the granted master's AW fields to s_AW*, with s_AWVALID = m_AWVALID[g]. m_AWREADY[g] = s_AWREADY. Latch s_AWLEN into beat_cnt. On the AW handshake go to DATA.
- DATA: forward W fields. s_WVALID = m_WVALID[g] and m_WREADY[g] = s_WREADY. beat_cnt decrements on each W handshake. On a W handshake with s_WLAST=1, go to RESP.
- RESP: s_BREADY = m_BREADY[g]. m_B*[g] = s_B*. m_BVALID of the other master stays 0. On the B handshake, set prio_last = g, clear grant, go to IDLE.
- The non-granted master sees READY=0 on all its channels and BVALID=0 at all times.
- Masters must hold VALID and payload stable until READY (AXI rule). The arbiter adds no buffering.

## Timing
- Reset (rst=0, async) values: state IDLE, grant=0, busy=0, prio_last=1, beat_cnt=0. All s_*VALID=0, s_BREADY=0, all m_*READY=0, m_BVALID=0, payload outputs 0.
- Reset mid-transaction aborts immediately. No partial beats are emitted after rst rises.
- Arbitration latency: m_AWVALID seen in IDLE at edge N, grant valid after edge N. s_AWVALID high in cycle N+1.
- Pass-through paths in ADDR/DATA/RESP are combinational, adding 0 cycles per beat.
- Turnaround: B handshake at edge M puts the FSM in IDLE. The next grant comes at edge M+1, so there is a 1-cycle bubble between transactions.
- Simultaneous m_AWVALID from both masters in IDLE: the round-robin rule decides. Alternating back-to-back requests alternate grants.
- A request from the other master arriving during ADDR/DATA/RESP waits. It is not lost, because the master holds its VALID.
- AWLEN=0 (single beat): DATA lasts until the first W handshake.

## Configuration
- AXI_WR_ARB_BEAT_CHK_EN defined: the arbiter drives s_WLAST from beat_cnt==0 instead of m_WLAST.
  - It adds output `len_err` (1 bit, sticky, cleared only by reset). len_err sets when m_WLAST disagrees with beat_cnt==0 on a W handshake.
  - The FSM leaves DATA on the beat where beat_cnt==0.
- Not defined: s_WLAST = m_WLAST[g], DATA exits on m_WLAST, and no len_err port exists.

## Test plan
- Single master 0, AWADDR=0x1000, AWLEN=3 -> grant=01 one cycle after AWVALID; 4 W beats reach slave; BRESP=0 returned on m_BVALID[0]; busy falls after B handshake.
- Both masters assert AWVALID in the same cycle from reset -> master 0 served first, master 1 granted one cycle after master 0's B handshake, grant order 01,10.
- Slave holds s_WREADY=0 for 3 cycles mid-burst -> m_WREADY[g]=0 for those cycles, no beat dropped or duplicated, data order preserved.
- rst pulsed low during DATA beat 2 of AWLEN=7 -> all outputs at reset values same cycle; next request is served from IDLE with master 0 priority.
- With AXI_WR_ARB_BEAT_CHK_EN: AWLEN=1 and master asserts WLAST on beat 0 -> len_err=1. s_WLAST asserted only on beat 1, and the transaction completes normally.
- AWLEN=0 from master 1 while master 0 idle -> one W beat with s_WLAST=1, grant=10, total AW-to-B path with 0-cycle forwarding.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-master round-robin AXI3 write-path arbiter
// Optional feature macro: AXI_WR_ARB_BEAT_CHK_EN (slave WLAST from beat counter, adds len_err)
module axi_wr_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_M-1:0][ID_W-1:0]          m_AWID,
    input  logic [NUM_M-1:0][ADDR_W-1:0]        m_AWADDR,
    input  logic [NUM_M-1:0][3:0]               m_AWLEN,
    input  logic [NUM_M-1:0][2:0]               m_AWSIZE,
    input  logic [NUM_M-1:0][1:0]               m_AWBURST,
    input  logic [NUM_M-1:0]                    m_AWVALID,
    output logic [NUM_M-1:0]                    m_AWREADY,
    input  logic [NUM_M-1:0][ID_W-1:0]          m_WID,
    input  logic [NUM_M-1:0][DATA_W-1:0]        m_WDATA,
    input  logic [NUM_M-1:0][DATA_W/8-1:0]      m_WSTRB,
    input  logic [NUM_M-1:0]                    m_WLAST,
    input  logic [NUM_M-1:0]                    m_WVALID,
    output logic [NUM_M-1:0]                    m_WREADY,
    output logic [NUM_M-1:0][ID_W-1:0]          m_BID,
    output logic [NUM_M-1:0][1:0]               m_BRESP,
    output logic [NUM_M-1:0]                    m_BVALID,
    input  logic [NUM_M-1:0]                    m_BREADY,
    output logic [ID_W-1:0]                     s_AWID,
    output logic [ADDR_W-1:0]                   s_AWADDR,
    output logic [3:0]                          s_AWLEN,
    output logic [2:0]                          s_AWSIZE,
    output logic [1:0]                          s_AWBURST,
    output logic                                s_AWVALID,
    input  logic                                s_AWREADY,
    output logic [ID_W-1:0]                     s_WID,
    output logic [DATA_W-1:0]                   s_WDATA,
    output logic [DATA_W/8-1:0]                 s_WSTRB,
    output logic                                s_WLAST,
    output logic                                s_WVALID,
    input  logic                                s_WREADY,
    input  logic [ID_W-1:0]                     s_BID,
    input  logic [1:0]                          s_BRESP,
    input  logic                                s_BVALID,
    output logic                                s_BREADY,
    output logic [NUM_M-1:0]                    grant,
`ifdef AXI_WR_ARB_BEAT_CHK_EN
    output logic                                len_err,
`endif
    output logic                                busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t             state_q;
    logic [NUM_M-1:0]   grant_q;
    logic               busy_q;
    logic               prio_last_q;
    logic [3:0]         beat_cnt_q;

    logic g;
    logic win;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic w_last;

    assign g     = grant_q[1];
    // On contention the master that was not served last wins.
    assign win   = (&m_AWVALID) ? ~prio_last_q : m_AWVALID[1];
    assign aw_hs = (state_q == ADDR) && m_AWVALID[g] && s_AWREADY;
    assign w_hs  = (state_q == DATA) && m_WVALID[g] && s_WREADY;
    assign b_hs  = (state_q == RESP) && s_BVALID && m_BREADY[g];

`ifdef AXI_WR_ARB_BEAT_CHK_EN
    logic len_err_q;

    assign w_last  = (beat_cnt_q == 4'd0);
    assign len_err = len_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_err_q <= 1'b0;
        end else if (w_hs && (m_WLAST[g] != w_last)) begin
            len_err_q <= 1'b1;
        end
    end
`else
    assign w_last = m_WLAST[g];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            prio_last_q <= 1'b1;
            beat_cnt_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: if (|m_AWVALID) begin
                    grant_q <= win ? 2'b10 : 2'b01;
                    busy_q  <= 1'b1;
                    state_q <= ADDR;
                end
                ADDR: if (aw_hs) begin
                    beat_cnt_q <= s_AWLEN;
                    state_q    <= DATA;
                end
                DATA: if (w_hs) begin
                    beat_cnt_q <= beat_cnt_q - 4'd1;
                    if (w_last) state_q <= RESP;
                end
                RESP: if (b_hs) begin
                    prio_last_q <= g;
                    grant_q     <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

    // Each channel is a zero-cycle pass-through that is only open in its own state.
    always_comb begin
        m_AWREADY = '0;
        m_WREADY  = '0;
        m_BID     = '0;
        m_BRESP   = '0;
        m_BVALID  = '0;
        s_AWID    = '0;
        s_AWADDR  = '0;
        s_AWLEN   = '0;
        s_AWSIZE  = '0;
        s_AWBURST = '0;
        s_AWVALID = 1'b0;
        s_WID     = '0;
        s_WDATA   = '0;
        s_WSTRB   = '0;
        s_WLAST   = 1'b0;
        s_WVALID  = 1'b0;
        s_BREADY  = 1'b0;
        case (state_q)
            ADDR: begin
                s_AWID       = m_AWID[g];
                s_AWADDR     = m_AWADDR[g];
                s_AWLEN      = m_AWLEN[g];
                s_AWSIZE     = m_AWSIZE[g];
                s_AWBURST    = m_AWBURST[g];
                s_AWVALID    = m_AWVALID[g];
                m_AWREADY[g] = s_AWREADY;
            end
            DATA: begin
                s_WID       = m_WID[g];
                s_WDATA     = m_WDATA[g];
                s_WSTRB     = m_WSTRB[g];
                s_WLAST     = w_last;
                s_WVALID    = m_WVALID[g];
                m_WREADY[g] = s_WREADY;
            end
            RESP: begin
                s_BREADY    = m_BREADY[g];
                m_BID[g]    = s_BID;
                m_BRESP[g]  = s_BRESP;
                m_BVALID[g] = s_BVALID;
            end
            default: ;
        endcase
    end

endmodule
